// File: rtl/and_or_pipeline_pkg.sv
// Shared constants and payload type for the and_or_pipeline datapath.
// The payload struct is width-generic through a macro because packages cannot take parameters.
`ifndef AND_OR_PAYLOAD_T
`define AND_OR_PAYLOAD_T(W) struct packed { logic [(W)-1:0] x; logic [(W)-1:0] y; }
`endif

package and_or_pipeline_pkg;
  localparam int MODE_FUSED = 0;
  localparam int MODE_SPLIT = 1;

  typedef `AND_OR_PAYLOAD_T(8) payload8_t;
endpackage

// File: rtl/pipe_reg_stage.sv
// One valid/ready payload register. It accepts new data whenever it is empty
// or its current beat leaves this cycle, so a full chain still streams at one beat per cycle.
module pipe_reg_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/and_or_pipeline.sv
// Pipelined x = a & b, y = x | c datapath with valid/ready handshaking.
// MODE_SPLIT combines c with the x of the previously accepted beat instead of the current one.
module and_or_pipeline
  import and_or_pipeline_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int MODE   = MODE_FUSED
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  input  logic [WIDTH-1:0]            c,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            x,
  output logic [WIDTH-1:0]            y,
  output logic [$clog2(STAGES+1)-1:0] out_count
);

  localparam int CW = $clog2(STAGES + 1);

  typedef `AND_OR_PAYLOAD_T(WIDTH) payload_t;

  // Index k is the link feeding stage k; index STAGES is the output port.
  logic     sv [STAGES+1];
  logic     sr [STAGES+1];
  payload_t sd [STAGES+1];

  logic [WIDTH-1:0] x_prev;
  logic [WIDTH-1:0] x_n;
  logic [WIDTH-1:0] y_n;
  logic             acc;
  logic             free;

  assign x_n = a & b;
  assign y_n = (MODE == MODE_SPLIT) ? (x_prev | c) : (x_n | c);

  assign sv[0]      = in_valid;
  assign sd[0]      = '{x: x_n, y: y_n};
  assign in_ready   = sr[0];
  assign sr[STAGES] = out_ready;
  assign out_valid  = sv[STAGES];
  assign x          = sd[STAGES].x;
  assign y          = sd[STAGES].y;

  assign acc  = in_valid && sr[0];
  assign free = out_valid && out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_reg_stage #(.W(2 * WIDTH)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sv[k]),
      .in_ready  (sr[k]),
      .in_data   (sd[k]),
      .out_valid (sv[k+1]),
      .out_ready (sr[k+1]),
      .out_data  (sd[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_prev <= '0;
    end else if (acc) begin
      x_prev <= x_n;
    end
  end

  // Tracks stage occupancy on the same edge the valids move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= '0;
    end else begin
      out_count <= out_count + CW'(acc) - CW'(free);
    end
  end

endmodule

// File: tb/tb_and_or_pipeline.sv
// Bench for and_or_pipeline: several parameter sets side by side, directed scenarios
// on the first two, and a queue scoreboard that checks every beat leaving every instance.
module tb_and_or_pipeline;

  localparam int NI = 6;
  localparam int MD [NI] = '{0, 1, 0, 1, 1, 0};
  localparam int ST [NI] = '{2, 2, 1, 4, 1, 4};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv   [NI];
  logic       ir   [NI];
  logic       ov   [NI];
  logic       ordy [NI];
  logic [7:0] a    [NI];
  logic [7:0] b    [NI];
  logic [7:0] c    [NI];
  logic [7:0] x    [NI];
  logic [7:0] y    [NI];
  logic [2:0] cnt  [NI];

  int errors = 0;
  int checks = 0;

  logic [15:0] q    [NI][$];
  logic [7:0]  xp_m [NI];

  for (genvar i = 0; i < NI; i++) begin : g
    logic [$clog2(ST[i]+1)-1:0] cnt_l;
    and_or_pipeline #(.WIDTH(8), .STAGES(ST[i]), .MODE(MD[i])) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[i]),
      .in_ready  (ir[i]),
      .a         (a[i]),
      .b         (b[i]),
      .c         (c[i]),
      .out_valid (ov[i]),
      .out_ready (ordy[i]),
      .x         (x[i]),
      .y         (y[i]),
      .out_count (cnt_l)
    );
    assign cnt[i] = 3'(cnt_l);
  end

  // Reference model: each accepted beat yields x = a&b and y = (a&b)|c, or in split
  // mode the x of the previous accepted beat OR c. Reset forgets everything in flight.
  initial begin
    logic [15:0] exp_v;
    logic [7:0]  xn;
    logic [7:0]  yn;
    for (int i = 0; i < NI; i++) xp_m[i] = 8'h00;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          q[i].delete();
          xp_m[i] = 8'h00;
        end else begin
          if (ov[i] && ordy[i]) begin
            checks++;
            if (q[i].size() == 0) begin
              errors++;
              $display("FAIL sb_extra inst%0d: got x=%h y=%h, expected no beat", i, x[i], y[i]);
            end else begin
              exp_v = q[i].pop_front();
              if ({x[i], y[i]} !== exp_v) begin
                errors++;
                $display("FAIL sb_beat inst%0d: got x=%h y=%h, expected x=%h y=%h",
                         i, x[i], y[i], exp_v[15:8], exp_v[7:0]);
              end
            end
          end
          if (iv[i] && ir[i]) begin
            xn = a[i] & b[i];
            yn = (MD[i] == 1) ? (xp_m[i] | c[i]) : (xn | c[i]);
            q[i].push_back({xn, yn});
            xp_m[i] = xn;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [7:0] av,
                       input logic [7:0] bv, input logic [7:0] cv);
    iv[i] = v;
    a[i]  = av;
    b[i]  = bv;
    c[i]  = cv;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      drive(i, 1'b0, 8'h00, 8'h00, 8'h00);
      ordy[i] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 32'(ov[0]), 0);
    chk("rst_x", 32'(x[0]), 0);
    chk("rst_y", 32'(y[1]), 0);
    chk("rst_count", 32'(cnt[3]), 0);
    rst_n = 1'b1;
    tick();

    // Fused mode, two-cycle latency
    drive(0, 1'b1, 8'hFF, 8'h0F, 8'h30);
    tick();
    iv[0] = 1'b0;
    chk("t1_not_yet", 32'(ov[0]), 0);
    tick();
    chk("t1_out_valid", 32'(ov[0]), 1);
    chk("t1_x", 32'(x[0]), 32'h0F);
    chk("t1_y", 32'(y[0]), 32'h3F);
    tick();

    // Split mode uses the previous beat's x
    drive(1, 1'b1, 8'hFF, 8'h0F, 8'h30);
    tick();
    drive(1, 1'b1, 8'h00, 8'hFF, 8'h00);
    tick();
    iv[1] = 1'b0;
    chk("t2_b1_valid", 32'(ov[1]), 1);
    chk("t2_b1_x", 32'(x[1]), 32'h0F);
    chk("t2_b1_y", 32'(y[1]), 32'h30);
    tick();
    chk("t2_b2_x", 32'(x[1]), 32'h00);
    chk("t2_b2_y", 32'(y[1]), 32'h0F);
    tick();

    // Backpressure fills the pipe, then drains in order
    ordy[0] = 1'b0;
    drive(0, 1'b1, 8'h3C, 8'hF0, 8'h01);
    tick();
    drive(0, 1'b1, 8'hAA, 8'h55, 8'h80);
    tick();
    drive(0, 1'b1, 8'h0F, 8'hFF, 8'h40);
    tick();
    chk("t3_in_ready_full", 32'(ir[0]), 0);
    chk("t3_count_full", 32'(cnt[0]), 2);
    chk("t3_out_valid", 32'(ov[0]), 1);
    chk("t3_x_hold", 32'(x[0]), 32'h30);
    chk("t3_y_hold", 32'(y[0]), 32'h31);
    tick();
    chk("t3_in_ready_still", 32'(ir[0]), 0);
    chk("t3_x_stable", 32'(x[0]), 32'h30);
    chk("t3_y_stable", 32'(y[0]), 32'h31);
    ordy[0] = 1'b1;
    #1;
    chk("t3_in_ready_free", 32'(ir[0]), 1);
    tick();
    iv[0] = 1'b0;
    chk("t3_count_swap", 32'(cnt[0]), 2);
    chk("t3_second_x", 32'(x[0]), 32'h00);
    chk("t3_second_y", 32'(y[0]), 32'h80);
    repeat (2) tick();
    chk("t3_count_drained", 32'(cnt[0]), 0);
    chk("t3_out_valid_drained", 32'(ov[0]), 0);

    // Full throughput: ten back-to-back beats
    for (int t = 0; t < 14; t++) begin
      drive(0, (t < 10), 8'($urandom), 8'($urandom), 8'($urandom));
      @(negedge clk);
      if (t < 10) chk($sformatf("t4_in_ready_c%0d", t), 32'(ir[0]), 1);
      chk($sformatf("t4_out_valid_c%0d", t), 32'(ov[0]), 32'((t >= 2) && (t < 12)));
      tick();
    end

    // Reset dropped between edges mid-stream
    for (int t = 0; t < 4; t++) begin
      drive(1, 1'b1, 8'hFF, 8'hFF, 8'($urandom));
      tick();
    end
    #2;
    rst_n = 1'b0;
    iv[1] = 1'b0;
    #1;
    chk("t5_out_valid", 32'(ov[1]), 0);
    chk("t5_x", 32'(x[1]), 0);
    chk("t5_y", 32'(y[1]), 0);
    chk("t5_count", 32'(cnt[1]), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    drive(1, 1'b1, 8'hFF, 8'hFF, 8'h12);
    tick();
    iv[1] = 1'b0;
    tick();
    chk("t5_first_valid", 32'(ov[1]), 1);
    chk("t5_first_x", 32'(x[1]), 32'hFF);
    chk("t5_first_y", 32'(y[1]), 32'h12);
    tick();

    // Random traffic on every instance
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NI; i++) begin
        drive(i, ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 8'($urandom));
        ordy[i] = ($urandom_range(0, 2) != 0);
      end
      tick();
    end
    for (int i = 0; i < NI; i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b1;
    end
    repeat (10) tick();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("sb_lost_inst%0d", i), 32'(q[i].size()), 0);
      chk($sformatf("end_count_inst%0d", i), 32'(cnt[i]), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
